// File: rtl/regfile_bypass_sb.sv
// Register file with two combinational read ports, two write-back ports,
// same-cycle write-to-read bypass and a per-register busy scoreboard.

module regfile_bypass_sb_entry #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int IDX       = 0,
    parameter bit HARD_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_wa0,
    input  logic [DATA_W-1:0] i_wd0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_wa1,
    input  logic [DATA_W-1:0] i_wd1,
    input  logic              i_issue,
    input  logic [ADDR_W-1:0] i_issue_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy
);
    localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(IDX);

    logic              w_hit0;
    logic              w_hit1;
    logic              w_iss;
    logic [DATA_W-1:0] r_data;
    logic              r_busy;

    // A hardwired-zero entry never matches, so it stays at its reset value.
    assign w_hit0 = i_we0   && (i_wa0 == MY_ADDR)        && !HARD_ZERO;
    assign w_hit1 = i_we1   && (i_wa1 == MY_ADDR)        && !HARD_ZERO;
    assign w_iss  = i_issue && (i_issue_addr == MY_ADDR) && !HARD_ZERO;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_busy <= 1'b0;
        end else begin
            if (w_hit1)
                r_data <= i_wd1;
            else if (w_hit0)
                r_data <= i_wd0;
            // A new producer wins over one retiring in the same cycle.
            if (w_iss)
                r_busy <= 1'b1;
            else if (w_hit0 || w_hit1)
                r_busy <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_busy = r_busy;
endmodule

module regfile_bypass_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write_back0,
    input  logic [ADDR_W-1:0]      write_addr0,
    input  logic [DATA_W-1:0]      write_data0,
    input  logic                   write_back1,
    input  logic [ADDR_W-1:0]      write_addr1,
    input  logic [DATA_W-1:0]      write_data1,
    input  logic [ADDR_W-1:0]      dst_addr,
    input  logic [ADDR_W-1:0]      src_addr,
    output logic [DATA_W-1:0]      read_data1,
    output logic [DATA_W-1:0]      read_data2,
    input  logic                   issue,
    input  logic [ADDR_W-1:0]      issue_addr,
    output logic                   dst_busy,
    output logic                   src_busy,
    output logic [(1<<ADDR_W)-1:0] busy_vec
);
    localparam int NUM_REGS = 1 << ADDR_W;

    logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;
    logic [NUM_REGS-1:0]             w_busy;
    logic [1:0][ADDR_W-1:0]          w_raddr;
    logic [1:0][DATA_W-1:0]          w_rdata;
    logic [1:0]                      w_rbusy;

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_reg
            regfile_bypass_sb_entry #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .IDX      (g),
                .HARD_ZERO((ZERO_REG != 0) && (g == 0))
            ) u_entry (
                .clk         (clk),
                .reset       (reset),
                .i_we0       (write_back0),
                .i_wa0       (write_addr0),
                .i_wd0       (write_data0),
                .i_we1       (write_back1),
                .i_wa1       (write_addr1),
                .i_wd1       (write_data1),
                .i_issue     (issue),
                .i_issue_addr(issue_addr),
                .o_data      (w_regs[g]),
                .o_busy      (w_busy[g])
            );
        end
    endgenerate

    assign w_raddr = {src_addr, dst_addr};

    // Later assignments win: stored < port 0 < port 1 < hardwired zero.
    // A register being written back is no longer busy since its data is bypassed.
    always_comb begin
        w_rdata = '0;
        w_rbusy = '0;
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = w_regs[w_raddr[p]];
            w_rbusy[p] = w_busy[w_raddr[p]];
            if (write_back0 && (write_addr0 == w_raddr[p])) begin
                w_rdata[p] = write_data0;
                w_rbusy[p] = 1'b0;
            end
            if (write_back1 && (write_addr1 == w_raddr[p])) begin
                w_rdata[p] = write_data1;
                w_rbusy[p] = 1'b0;
            end
            if ((ZERO_REG != 0) && (w_raddr[p] == '0))
                w_rdata[p] = '0;
        end
    end

    assign read_data1 = w_rdata[0];
    assign read_data2 = w_rdata[1];
    assign dst_busy   = w_rbusy[0];
    assign src_busy   = w_rbusy[1];
    assign busy_vec   = w_busy;
endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
Parametrised general-purpose register file for the pipelined processor core. It has two asynchronous read ports (dst and src) and two write-back ports. Same-cycle write-to-read bypass lets decode see write-back data without a negedge write. A per-register busy scoreboard tracks in-flight producers so decode can stall on RAW hazards.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W (derived, not overridable)
ZERO_REG, 0, 1 = register 0 hardwired to zero (writes ignored, never busy)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous active-high reset
write_back0  input  1  write enable, write port 0
write_addr0  input  ADDR_W  write address, port 0
write_data0  input  DATA_W  write data, port 0
write_back1  input  1  write enable, write port 1 (higher priority)
write_addr1  input  ADDR_W  write address, port 1
write_data1  input  DATA_W  write data, port 1
dst_addr  input  ADDR_W  read address, port 1
src_addr  input  ADDR_W  read address, port 2
read_data1  output  DATA_W  data for dst_addr (combinational)
read_data2  output  DATA_W  data for src_addr (combinational)
issue  input  1  decode issued an instruction that will write issue_addr
issue_addr  input  ADDR_W  destination of the issued instruction
dst_busy  output  1  dst_addr has a pending producer
src_busy  output  1  src_addr has a pending producer
busy_vec  output  NUM_REGS  raw scoreboard bits, bit i = register i

Behaviour:
- Reset: clk and reset as named. Reset is synchronous and active-high: on a rising edge with reset=1, all NUM_REGS registers clear to 0 and all busy bits clear.
  - Writes and issue presented in the reset cycle are discarded.
  - Outputs are combinational from state, so after the reset edge read_data1/2 = 0, dst_busy = src_busy = 0 and busy_vec = 0.
  - Reset asserted mid-sequence aborts all pending state; there is no partial retention.
- Write:
  - On a rising edge with write_backN=1, registers[write_addrN] <= write_dataN.
  - When both ports target the same address in one cycle, port 1 data is stored.
  - Distinct addresses: both are written.
- Read: combinational, zero latency. read_data1 is selected by dst_addr and read_data2 by src_addr, each with bypass in this priority:
  - (a) ZERO_REG=1 and addr=0 -> 0;
  - (b) write_back1 & write_addr1==addr -> write_data1;
  - (c) write_back0 & write_addr0==addr -> write_data0;
  - (d) stored value.
  - Net effect: a read in the same cycle as a write returns the new data, replacing the legacy negedge-write scheme.
- ZERO_REG=1:
  - Writes to address 0 have no effect.
  - issue to address 0 never sets busy.
  - busy_vec[0] is always 0.
- Scoreboard, per register i, next-state priority:
  - reset -> 0;
  - else issue & issue_addr==i -> 1 (a new producer overrides a retiring one);
  - else (write_back0 & write_addr0==i) | (write_back1 & write_addr1==i) -> 0;
  - else hold.
  - Write-back to a register that is not busy is legal and leaves busy at 0.
- Busy outputs are bypass-aware. dst_busy = busy[dst_addr] & ~(write-back to dst_addr this cycle), and likewise src_busy for src_addr. This works because the bypassed data is already valid. The issue input does not affect dst_busy/src_busy in the same cycle.
- busy_vec is the registered state only, with no bypass.
- All address inputs are full range, so there is no out-of-range case and reset loops cover exactly NUM_REGS entries.

Test Plan:
- Reset then read: assert reset 1 cycle with write_back0=1, addr 3, data 0xBEEF -> after the edge, all reads of r0..r7 return 0x0000 and busy_vec=8'h00.
- Write/read plus bypass: write r5=0x1234 via port 0; in the same cycle dst_addr=5 -> read_data1=0x1234 combinationally; next cycle, with no write, it is still 0x1234.
- Dual-port collision: the same cycle has port0 r2=0xAAAA and port1 r2=0x5555 -> read_data2 (src=2) shows 0x5555 in that cycle and after the edge.
- Scoreboard: issue r4 -> next cycle busy_vec=8'h10 and src_busy=1 (src=4). A write-back of r4=0x0042 makes src_busy=0 and read_data2=0x0042 that cycle, and busy_vec=0 after the edge.
- Issue/retire collision: r6 busy; in one cycle issue r6 and write-back r6=0x7777 -> after the edge busy_vec[6]=1 and r6 holds 0x7777.
- ZERO_REG=1 instance: write r0=0xFFFF and issue r0 -> read of r0 returns 0x0000 in the same and the following cycle; busy_vec[0]=0.
